// File: rtl/tt_um_vending_machine.sv
// Coin vending controller: nickel/dime/quarter credit, one-cycle vend pulse, then one-cycle change/refund pulse.
// Outputs are registered Moore decodes (one edge after a coin); no backpressure, coins during VEND/CHANGE are dropped.
module tt_um_vending_machine (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VEND    = 2'b10,
    CHANGE  = 2'b11
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] credit, credit_nxt;
  logic [5:0] prev;
  logic [5:0] edges;
  logic [5:0] coin;
  logic [5:0] price;
  logic [5:0] next_credit;
  logic       cancel_edge;
  logic       unused_ok;

  assign unused_ok   = ^{ena, uio_in, ui_in[7:6]};
  assign edges       = ui_in[5:0] & ~prev;
  assign cancel_edge = edges[5];
  assign next_credit = credit + coin;

  // Simultaneous coin edges are ambiguous, so the whole cycle's coins are dropped.
  always_comb begin
    case (edges[2:0])
      3'b001:  coin = 6'd5;
      3'b010:  coin = 6'd10;
      3'b100:  coin = 6'd25;
      default: coin = 6'd0;
    endcase
  end

  always_comb begin
    case (ui_in[4:3])
      2'b00:   price = 6'd15;
      2'b01:   price = 6'd20;
      2'b10:   price = 6'd25;
      default: price = 6'd30;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      credit <= 6'd0;
      prev   <= 6'd0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      prev   <= ui_in[5:0];
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    case (state)
      IDLE: begin
        if (coin != 6'd0) begin
          if (next_credit >= price) begin
            state_nxt  = VEND;
            credit_nxt = next_credit - price;
          end else begin
            state_nxt  = COLLECT;
            credit_nxt = next_credit;
          end
        end
      end
      COLLECT: begin
        // A cheaper select can complete the sale even without a coin this cycle.
        if (cancel_edge) begin
          state_nxt = CHANGE;
        end else if (next_credit >= price) begin
          state_nxt  = VEND;
          credit_nxt = next_credit - price;
        end else begin
          credit_nxt = next_credit;
        end
      end
      VEND: begin
        state_nxt = (credit != 6'd0) ? CHANGE : IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = 6'd0;
      end
    endcase
  end

  always_comb begin
    uo_out  = {4'b0000, state, state == CHANGE, state == VEND};
    uio_out = {2'b00, credit};
    uio_oe  = 8'h3F;
  end

endmodule

// File: tb/tb_tt_um_vending_machine.sv
// Bench for tt_um_vending_machine: scheduled-output model compared every cycle plus literal spot checks.
module tb_tt_um_vending_machine;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int n_cmp = 0;
  int n_bad = 0;
  logic check_en = 1'b0;

  tt_um_vending_machine dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a sale or refund schedules its whole output sequence; while that
  // schedule drains the machine ignores inputs. Otherwise credit just accumulates.
  logic [5:0] m_prev;
  int         m_credit;
  logic [7:0] exp_uo;
  logic [7:0] exp_uio;
  logic [7:0] q_uo[$];
  logic [7:0] q_uio[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev   <= 6'd0;
      m_credit <= 0;
      exp_uo   <= 8'h00;
      exp_uio  <= 8'h00;
      q_uo.delete();
      q_uio.delete();
    end else begin
      logic [5:0] e;
      int         coin;
      int         price;
      int         cr;
      logic [7:0] nuo;
      logic [7:0] nuio;
      e     = ui_in[5:0] & ~m_prev;
      coin  = 0;
      if ($countones(e[2:0]) == 1)
        coin = e[0] ? 5 : (e[1] ? 10 : 25);
      price = 15 + 5 * int'(ui_in[4:3]);
      cr    = m_credit;
      if (q_uo.size() > 0) begin
        nuo  = q_uo.pop_front();
        nuio = q_uio.pop_front();
      end else if (cr > 0 && e[5]) begin
        nuo  = 8'h0E;
        nuio = 8'(cr);
        q_uo.push_back(8'h00);
        q_uio.push_back(8'h00);
        cr = 0;
      end else if ((coin > 0 || cr > 0) && (cr + coin >= price)) begin
        cr   = cr + coin - price;
        nuo  = 8'h09;
        nuio = 8'(cr);
        if (cr > 0) begin
          q_uo.push_back(8'h0E);
          q_uio.push_back(8'(cr));
        end
        q_uo.push_back(8'h00);
        q_uio.push_back(8'h00);
        cr = 0;
      end else begin
        cr   = cr + coin;
        nuo  = (cr > 0) ? 8'h04 : 8'h00;
        nuio = 8'(cr);
      end
      m_prev   <= ui_in[5:0];
      m_credit <= cr;
      exp_uo   <= nuo;
      exp_uio  <= nuio;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      n_cmp = n_cmp + 3;
      if (uo_out !== exp_uo) begin
        n_bad = n_bad + 1;
        $display("FAIL model_uo_out t=%0t got=%h want=%h", $time, uo_out, exp_uo);
      end
      if (uio_out !== exp_uio) begin
        n_bad = n_bad + 1;
        $display("FAIL model_uio_out t=%0t got=%h want=%h", $time, uio_out, exp_uio);
      end
      if (uio_oe !== 8'h3F) begin
        n_bad = n_bad + 1;
        $display("FAIL model_uio_oe t=%0t got=%h want=3f", $time, uio_oe);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Apply a vector away from the edge, then let one rising edge sample it.
  task automatic step(input logic [7:0] v);
    @(negedge clk);
    ui_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] uo, input logic [7:0] uio);
    lit({name, "_uo"}, uo_out, uo);
    lit({name, "_uio"}, uio_out, uio);
  endtask

  initial begin
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    rst_n  = 1'b0;
    #2;
    check_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 8'h00, 8'h00);
    lit("reset_oe", uio_oe, 8'h3F);
    @(negedge clk);
    rst_n = 1'b1;

    // Three nickels at 15c: exact payment, no change.
    step(8'h01); expect_out("n1", 8'h04, 8'd5);
    step(8'h00); expect_out("n1_hold", 8'h04, 8'd5);
    step(8'h01); expect_out("n2", 8'h04, 8'd10);
    step(8'h00);
    step(8'h01); expect_out("n3_vend", 8'h09, 8'd0);
    step(8'h00); expect_out("n3_idle", 8'h00, 8'd0);

    // Quarter at 15c: vend then 10c change.
    step(8'h04); expect_out("q_vend", 8'h09, 8'd10);
    step(8'h00); expect_out("q_change", 8'h0E, 8'd10);
    step(8'h00); expect_out("q_idle", 8'h00, 8'd0);

    // Dime at 30c then cancel refunds 10c.
    step(8'h1A); expect_out("c_collect", 8'h04, 8'd10);
    step(8'h18);
    step(8'h38); expect_out("c_refund", 8'h0E, 8'd10);
    step(8'h18); expect_out("c_idle", 8'h00, 8'd0);

    // Two coins in one cycle are dropped; a held dime counts once.
    step(8'h03); expect_out("dual", 8'h00, 8'd0);
    step(8'h00);
    for (int i = 0; i < 5; i++) step(8'h02);
    expect_out("held_dime", 8'h04, 8'd10);
    step(8'h22); expect_out("held_cancel", 8'h0E, 8'd10);
    step(8'h00); expect_out("held_idle", 8'h00, 8'd0);

    // 20c at 30c, then select drops to 15c: vend with 5c change.
    step(8'h1A); step(8'h18); step(8'h1A); step(8'h18);
    expect_out("sel_collect", 8'h04, 8'd20);
    step(8'h00); expect_out("sel_vend", 8'h09, 8'd5);
    step(8'h00); expect_out("sel_change", 8'h0E, 8'd5);
    step(8'h00); expect_out("sel_idle", 8'h00, 8'd0);

    // Highest reachable credit: two quarters at 30c gives 50c, 20c change.
    step(8'h1C); step(8'h18); step(8'h1C);
    expect_out("max_vend", 8'h09, 8'd20);
    step(8'h18); expect_out("max_change", 8'h0E, 8'd20);
    step(8'h18);

    // Reset during VEND aborts the change pulse.
    step(8'h04); expect_out("abort_vend", 8'h09, 8'd10);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("abort_reset", 8'h00, 8'd0);
    // A nickel held across reset release counts at the first edge.
    @(negedge clk);
    ui_in = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("held_reset", 8'h04, 8'd5);
    step(8'h21); expect_out("final_refund", 8'h0E, 8'd5);
    step(8'h00); expect_out("final_idle", 8'h00, 8'd0);
    step(8'h00);

    @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
